// File: rtl/hs_pkg.sv
// Helpers shared by the hs_utils handshake stages.
package hs_pkg;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or above ptr, modulo N.
module hs_rr_pick #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    int unsigned idx;

    // Scan from farthest to nearest so the nearest requester overwrites and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (32'(ptr) + 32'(k)) % N;
            if (req[IW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin merge of N handshake streams onto one registered output, with packet lock.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDTH = 1,
    localparam int IW    = $clog2(N)
) (
    input  logic                      clk_core,
    input  logic                      rst_core_n,
    output logic                      stall,
    input  logic                      flush_req,
    input  logic [N-1:0][WIDTH-1:0]   in,
    input  logic [N-1:0]              in_last,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    output logic [WIDTH-1:0]          out,
    output logic [IW-1:0]             out_id,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [IW-1:0]    ptr_q, ptr_d, owner_q, owner_d, out_id_q, out_id_d;
    logic             locked_q, locked_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             load, pick_valid, sel_valid, xfer;
    logic [IW-1:0]    pick_idx, sel_idx;

    assign load = ~out_valid_q | out_ready;

    hs_rr_pick #(.N(N)) u_pick (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // While locked the owner keeps the slot even with in_valid low.
    assign sel_idx   = locked_q ? owner_q : pick_idx;
    assign sel_valid = locked_q | pick_valid;

    always_comb begin
        in_ready = '0;
        if (rst_core_n && load && !flush_req && sel_valid)
            in_ready[sel_idx] = 1'b1;
    end

    assign xfer = in_valid[sel_idx] & in_ready[sel_idx];

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        out_d       = out_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (flush_req) begin
            out_valid_d = 1'b0;
            locked_d    = 1'b0;
        end else if (xfer) begin
            out_d       = in[sel_idx];
            out_id_d    = sel_idx;
            out_last_d  = in_last[sel_idx];
            out_valid_d = 1'b1;
            if (in_last[sel_idx]) begin
                locked_d = 1'b0;
                ptr_d    = IW'(wrap_inc(32'(sel_idx), N));
            end else begin
                locked_d = 1'b1;
                owner_d  = sel_idx;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            locked_q    <= 1'b0;
            out_q       <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            locked_q    <= locked_d;
            out_q       <= out_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign stall     = out_valid_q & ~out_ready;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed plus randomized check of hs_rr_arbiter against a behavioural model.
module tb_hs_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, flush, out_ready, stall, out_last, out_valid;
    logic [N-1:0][W-1:0]  din;
    logic [N-1:0]         in_last, in_valid, in_ready;
    logic [W-1:0]         dout;
    logic [1:0]           out_id;

    hs_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk_core   (clk),
        .rst_core_n (rst_n),
        .stall      (stall),
        .flush_req  (flush),
        .in         (din),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (dout),
        .out_id     (out_id),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: rotating pointer, packet owner, and the output slot.
    int          m_ptr, m_owner, m_id;
    bit          m_locked, m_ov, m_last;
    logic [W-1:0] m_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_owner = 0; m_id = 0;
        m_locked = 0; m_ov = 0; m_last = 0; m_out = '0;
    endtask

    function automatic int m_grant();
        if (!rst_n || flush || !(!m_ov || out_ready)) return -1;
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic step();
        int g;
        logic [N-1:0] r;
        #1;
        g = m_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(r));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out", 32'(dout), 32'(m_out));
        chk("out_id", 32'(out_id), 32'(m_id));
        chk("out_last", 32'(out_last), 32'(m_last));
        chk("stall", 32'(stall), 32'(m_ov && !out_ready));
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                m_ov = 0;
                m_locked = 0;
            end else if (g >= 0 && in_valid[g]) begin
                m_out = din[g]; m_id = g; m_last = in_last[g]; m_ov = 1;
                if (in_last[g]) begin
                    m_locked = 0;
                    m_ptr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner = g;
                end
            end else if (!m_ov || out_ready) begin
                m_ov = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; flush = 0; out_ready = 1;
        in_valid = '1; in_last = '1;
        for (int i = 0; i < N; i++) din[i] = W'(8'h10 + i);
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_out", 32'(dout), 0);
        step();
        step();

        // Fairness: everyone valid with single-beat packets.
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair_id", 32'(out_id), 32'(k % 4));
        end

        // Packet lock: requester 0 sends A,B,C while 1 waits with D.
        in_valid = 4'b0011; in_last = 4'b0010;
        din[0] = 8'h0A; din[1] = 8'h0D;
        #1 chk("lock_rdy1", 32'(in_ready[1]), 0);
        step(); chk("lock_A", 32'(dout), 8'h0A);
        din[0] = 8'h0B;
        #1 chk("lock_rdy1", 32'(in_ready[1]), 0);
        step(); chk("lock_B", 32'(dout), 8'h0B);
        din[0] = 8'h0C; in_last[0] = 1'b1;
        #1 chk("lock_rdy1", 32'(in_ready[1]), 0);
        step(); chk("lock_C", 32'(dout), 8'h0C); chk("lock_C_id", 32'(out_id), 0);
        in_valid = 4'b0010;
        step(); chk("lock_D", 32'(dout), 8'h0D); chk("lock_D_id", 32'(out_id), 1);

        // Backpressure with 0x5 held in the output register.
        in_valid = 4'b0100; in_last = '1; din[2] = 8'h05;
        step(); chk("bp_load", 32'(dout), 8'h05);
        out_ready = 0; in_valid = '1;
        repeat (3) begin
            #1;
            chk("bp_out", 32'(dout), 8'h05);
            chk("bp_stall", 32'(stall), 1);
            chk("bp_rdy", 32'(in_ready), 0);
            step();
        end
        out_ready = 1; in_valid = '0;
        step(); chk("bp_drain", 32'(out_valid), 0);

        // Flush while requester 2 holds the lock; next grant follows ptr (3).
        in_valid = 4'b0100; in_last = '0; din[2] = 8'h21;
        step(); chk("fl_beat1_id", 32'(out_id), 2);
        flush = 1; in_valid = 4'b0101; in_last = '1; din[0] = 8'h30;
        #1 chk("fl_rdy", 32'(in_ready), 0);
        step(); chk("fl_ov", 32'(out_valid), 0);
        flush = 0;
        step(); chk("fl_next_id", 32'(out_id), 0);

        // Async reset in the middle of a packet.
        in_valid = 4'b0001; in_last = '0;
        step();
        in_valid = '1;
        #2 rst_n = 0;
        m_reset();
        #1;
        chk("arst_ov", 32'(out_valid), 0);
        chk("arst_rdy", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1; in_valid = 4'b1010; in_last = '1;
        step(); chk("arst_first_id", 32'(out_id), 1);

        // Sparse: bring ptr to 1, then only requester 3 valid.
        in_valid = 4'b0001;
        step();
        in_valid = 4'b1000;
        step(); chk("sparse_id", 32'(out_id), 3);
        in_valid = '1;
        step(); chk("sparse_wrap_id", 32'(out_id), 0);

        repeat (400) begin
            in_valid  = N'($urandom);
            in_last   = N'($urandom);
            for (int i = 0; i < N; i++) din[i] = W'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 16) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs_rr_arbiter.md
# hs_rr_arbiter

Round-robin arbiter that merges N valid/ready handshake streams onto one registered output stream. Multi-beat packets are supported: a grant is held from a packet's first beat until its `last` beat. The block sits in front of shared handshake consumers, for example a single skid-buffered pipeline stage or a shared bus port. It also drives the common stall/flush controls the same way the other `hs_utils` stages do.

## Interface
Parameters:
- `N`, 2: number of requesters; must be ≥ 2.
- `WIDTH`, 1: payload bits per beat.

Ports:
- `clk_core`, in, 1: core clock.
- `rst_core_n`, in, 1: reset, asynchronous, active-low.
- `stall`, out, 1: `out_valid & ~out_ready`, i.e. the output register is blocked.
- `flush_req`, in, 1: synchronous flush of the output register and the packet lock.
- `in`, in, `[N-1:0][WIDTH-1:0]`: per-requester payload.
- `in_last`, in, `[N-1:0]`: per-requester end-of-packet flag.
- `in_valid`, in, `[N-1:0]`: per-requester valid.
- `in_ready`, out, `[N-1:0]`: per-requester ready; at most one bit high (one-hot or zero).
- `out`, out, `WIDTH`: registered payload.
- `out_id`, out, `$clog2(N)`: index of the requester that supplied `out`.
- `out_last`, out, 1: registered `last` flag.
- `out_valid`, out, 1: registered valid.
- `out_ready`, in, 1: downstream ready.

## Operation
- **Output register.** `load = ~out_valid | out_ready`. A beat from requester i transfers when `in_valid[i] & in_ready[i]`. On a transfer: `out <= in[i]`, `out_id <= i`, `out_last <= in_last[i]`, `out_valid <= 1`. If `load` is high and no transfer happens, then `out_valid <= 0`.
- **State.**
  - `ptr` (`$clog2(N)` bits): highest-priority index.
  - `locked` (1 bit).
  - `owner` (`$clog2(N)` bits).
- **Arbitration when unlocked.**
  - Grant the first requester with `in_valid` high, scanning from `ptr` upward modulo N.
  - `in_ready[g] = load & ~flush_req`. All other `in_ready` bits are 0.
- **Arbitration when locked.**
  - Only `owner` is eligible: `in_ready[owner] = load & ~flush_req`.
  - Other requesters see 0, even if `owner` currently has `in_valid` low.
- **Updates on each transfer from requester i.**
  - If `in_last[i]` is high: `locked <= 0` and `ptr <= (i+1) mod N`. Wrap-around: i = N-1 gives `ptr` = 0.
  - If `in_last[i]` is low: `locked <= 1` and `owner <= i`.
  - A single-beat packet (first beat has `last` high) never sets `locked`.
- **Flush.** When `flush_req` is high:
  - No transfer occurs, because all `in_ready` bits are 0.
  - Next cycle: `out_valid <= 0`, `locked <= 0`.
  - `ptr` is kept unchanged.
  - `flush_req` takes priority over every other update in the same cycle.
- **`ptr` on idle cycles.** `ptr` changes only on transfers with `last` high.

## Timing
- **Reset values.** With `rst_core_n` low, all of the following are 0: `out`, `out_id`, `out_last`, `out_valid`, `stall`, `ptr`, `locked`, `owner`. `in_ready` is forced to 0 while reset is asserted.
- **Reset mid-packet.** Releases the lock and discards the beat held in the output register.
- **Latency.** An input handshake in cycle t gives `out_valid` high in cycle t+1.
- **Throughput.** One beat per cycle: when `out_valid & out_ready`, a new beat loads in the same cycle.
- **In-handshake combinational path.** `in_ready` depends combinationally on `out_ready`, `in_valid`, `flush_req` and the state registers. It never depends on `in_ready`.
- **Output stability.** While `out_valid & ~out_ready`, the values of `out`, `out_id` and `out_last` are held stable.
- **Simultaneous events.**
  - Output drain plus new grant in the same cycle: allowed.
  - `flush_req` together with `out_ready`: the flush wins, the output goes invalid, and no new beat is accepted.

## Structure
- Sub-module `hs_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Instantiated once.
- Shared `hs_pkg` holds no types for this block. The index width `$clog2(N)` is a local parameter.

## Test plan
- **Fairness.** N=4, all `in_valid` high, all `in_last` high, `out_ready` high → `out_id` sequence 0,1,2,3,0,1 at one beat per cycle.
- **Packet lock.** N=2. Requester 0 sends a 3-beat packet (payloads 0xA,0xB,0xC; `last` on the third beat) while requester 1 holds `in_valid` high with 0xD, `last` high → output sequence A,B,C,D with `out_id` 0,0,0,1. `in_ready[1]` stays 0 during the packet.
- **Backpressure.** Drop `out_ready` for 3 cycles with a beat 0x5 in the output register → `out` holds 0x5, `stall` is high, all `in_ready` are 0; the beat drains in the cycle `out_ready` returns, with no loss or duplication.
- **Flush while locked.** Assert `flush_req` after beat 1 of a 3-beat packet from requester 2 → next cycle `out_valid` is 0 and `locked` is 0. The next grant follows `ptr`, which is unchanged, rather than favouring requester 2.
- **Async reset mid-packet.** Assert `rst_core_n` low asynchronously in the middle of a packet → `out_valid` and `in_ready` go to 0 immediately. After release, the first grant goes to the lowest valid index scanning from 0.
- **Sparse requests.** Only requester 3 is valid, N=4, `ptr`=1 → grant 3 and `ptr` becomes 0.
